load_store_unit: RTL and testbench

Byte-addressed load/store front end that sits directly upstream of the word-wide BRAM `Memory` block and drives its active-low `rd_i`/`wr_i` strobes. It accepts one RV32I access at a time from the core (LB/LH/LW/LBU/LHU/SB/SH/SW). It converts the byte address to a word address, sign- or zero-extends load lanes, and performs read-modify-write for sub-word stores, because the memory has no byte enables. Misaligned and illegal accesses are rejected without touching memory.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-wide BRAM without byte enables.
// Sub-word stores are done as read-modify-write; misaligned/illegal accesses never strobe memory.
`ifndef MEM_WORDS
`define MEM_WORDS 8
`endif

module load_store_unit #(
  parameter int WORDS = `MEM_WORDS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       funct3_i,
  input  logic [WORDS+1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      rdata_o,
  output logic [WORDS-1:0] mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  input  logic [31:0]      mem_data_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WORDS+1:0] addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic [31:0]      rdata_q, rdata_d;

  function automatic logic illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3, bad_st, mis;
    bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    bad_st = we && f3[2];
    mis    = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || bad_st || mis;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {a, 3'b000};
    case (f3)
      3'b000:  res = 32'($signed(sh[7:0]));
      3'b001:  res = 32'($signed(sh[15:0]));
      3'b100:  res = {24'h0, sh[7:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Only the addressed byte/half is replaced; halves are always 16-bit aligned here.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = {a, 3'b000};
    mask = f3[0] ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d = addr_i;
          f3_d   = funct3_i;
          we_d   = we_i;
          wbuf_d = wdata_i;
          err_d  = illegal(we_i, funct3_i, addr_i[1:0]);
          if (err_d)                            state_d = DONE;
          else if (we_i && funct3_i == 3'b010) state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ: begin
        if (we_q) begin
          wbuf_d  = merge(mem_data_i, wbuf_q, f3_q, addr_q[1:0]);
          state_d = WRITE;
        end else begin
          rdata_d = extract(mem_data_i, f3_q, addr_q[1:0]);
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode purely from registers so they are stable when memory samples on negedge.
  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == DONE) && err_q;
  assign mem_rd_o   = (state_q != READ);
  assign mem_wr_o   = (state_q != WRITE);
  assign mem_addr_o = addr_q[WORDS+1:2];
  assign mem_data_o = wbuf_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: negedge BRAM model plus a byte-level reference of memory and rdata.
module tb_load_store_unit;
  localparam int WORDS = 6;
  localparam int NW    = 1 << WORDS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             we  = 1'b0;
  logic [2:0]       f3  = '0;
  logic [WORDS+1:0] addr = '0;
  logic [31:0]      wdata = '0;
  logic             ready_o, done_o, err_o, mem_rd_o, mem_wr_o;
  logic [31:0]      rdata_o, mem_data_o, mem_data_i;
  logic [WORDS-1:0] mem_addr_o;

  logic [31:0] mem [NW];
  logic [31:0] mem_q = '0;
  logic [31:0] ref_mem [NW];
  logic [31:0] ref_rdata = '0;

  int total = 0;
  int bad   = 0;
  int rd_lo = 0, wr_lo = 0, both_lo = 0, done_cnt = 0;
  logic [WORDS-1:0] wr_addr_seen = '0;
  logic [31:0]      wr_data_seen = '0;

  always #5 clk = ~clk;

  load_store_unit #(.WORDS(WORDS)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_data_i(mem_data_i)
  );

  assign mem_data_i = mem_q;

  always @(negedge clk) begin
    if (!mem_wr_o) mem[mem_addr_o] <= mem_data_o;
    if (!mem_rd_o) mem_q <= mem[mem_addr_o];
  end

  always @(negedge clk) begin
    if (!mem_rd_o) rd_lo++;
    if (!mem_wr_o) begin
      wr_lo++;
      wr_addr_seen = mem_addr_o;
      wr_data_seen = mem_data_o;
    end
    if (!mem_rd_o && !mem_wr_o) both_lo++;
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input bit w, input int f, input int a);
    if (f == 3 || f >= 6) return 1'b0;
    if (w && f >= 4) return 1'b0;
    if ((f == 1 || f == 5) && (a % 2) != 0) return 1'b0;
    if (f == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nbytes(input int f);
    return (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
  endfunction

  // Assemble the little-endian lane value, then apply two's-complement sign if requested.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int f, input int a);
    int     n, k;
    longint v;
    n = nbytes(f);
    k = a % 4;
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(word[8*(k+i) +: 8]);
    if (f < 4 && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wd,
                                            input int f, input int a);
    int          n, k;
    logic [31:0] r;
    n = nbytes(f);
    k = a % 4;
    r = word;
    for (int i = 0; i < n; i++) r[8*(k+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic access(input bit w, input int f, input int a, input logic [31:0] wd);
    bit          ok;
    int          wi, exp_lat, exp_rd, exp_wr, rd0, wr0, dn0, cyc;
    logic [31:0] exp_word;
    ok       = legal(w, f, a);
    wi       = a / 4;
    exp_lat  = !ok ? 0 : (!w ? 1 : (f == 2 ? 2 - 1 : 2));
    exp_rd   = (ok && !(w && f == 2)) ? 1 : 0;
    exp_wr   = (ok && w) ? 1 : 0;
    exp_word = ref_mem[wi];
    if (ok && w)  exp_word  = ref_store(ref_mem[wi], wd, f, a);
    if (ok && !w) ref_rdata = ref_load(ref_mem[wi], f, a);
    @(negedge clk);
    chk("ready_before", 32'(ready_o), 32'd1);
    req = 1'b1; we = w; f3 = f[2:0]; addr = a[WORDS+1:0]; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    rd0 = rd_lo; wr0 = wr_lo; dn0 = done_cnt;
    cyc = 0;
    while (!done_o && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("err", 32'(err_o), 32'(!ok));
    chk("rdata", rdata_o, ref_rdata);
    @(posedge clk); #1;
    chk("rd_strobes", 32'(rd_lo - rd0), 32'(exp_rd));
    chk("wr_strobes", 32'(wr_lo - wr0), 32'(exp_wr));
    chk("done_pulses", 32'(done_cnt - dn0), 32'd1);
    chk("ready_after", 32'(ready_o), 32'd1);
    chk("mem_word", mem[wi], exp_word);
    if (ok && w) begin
      chk("wr_addr", 32'(wr_addr_seen), 32'(wi));
      chk("wr_data", wr_data_seen, exp_word);
    end
    ref_mem[wi] = exp_word;
  endtask

  initial begin
    int f, a, rd0, wr0, dn0;
    bit w;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NW; i++) access(1'b1, 2, i * 4, $urandom);

    access(1'b1, 2, 'h10, 32'hDEADBEEF);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);
    chk("sw_addr", 32'(wr_addr_seen), 32'd4);
    access(1'b0, 2, 'h10, 32'h0);
    chk("lw", rdata_o, 32'hDEADBEEF);
    access(1'b1, 2, 'h10, 32'h11223344);
    access(1'b1, 0, 'h13, 32'h000000A5);
    chk("sb_merge", wr_data_seen, 32'hA5223344);
    access(1'b0, 0, 'h13, 32'h0);
    chk("lb", rdata_o, 32'hFFFFFFA5);
    access(1'b0, 4, 'h13, 32'h0);
    chk("lbu", rdata_o, 32'h000000A5);
    access(1'b0, 1, 'h12, 32'h0);
    chk("lh", rdata_o, 32'hFFFFA522);
    access(1'b0, 5, 'h10, 32'h0);
    chk("lhu", rdata_o, 32'h00003344);

    access(1'b0, 2, 'h06, 32'h0);
    access(1'b1, 1, 'h11, 32'h12345678);
    access(1'b0, 3, 'h10, 32'h0);
    chk("err_keep_rdata", rdata_o, 32'h00003344);

    // Reset while an SH is in its read phase: nothing may reach memory.
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = 3'b001; addr = 8'h12; wdata = $urandom;
    @(posedge clk); #1;
    req = 1'b0;
    wr0 = wr_lo; dn0 = done_cnt;
    chk("abort_in_read", 32'(mem_rd_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_rd_off", 32'(mem_rd_o), 32'd1);
    chk("abort_wr_off", 32'(mem_wr_o), 32'd1);
    chk("abort_ready", 32'(ready_o), 32'd1);
    ref_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_write", 32'(wr_lo - wr0), 32'd0);
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    chk("abort_mem4", mem[4], ref_mem[4]);
    access(1'b0, 2, 'h10, 32'h0);

    // Asynchronous reset from idle, checked before any clock edge.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_rdata", rdata_o, 32'd0);
    chk("arst_rd", 32'(mem_rd_o), 32'd1);
    chk("arst_wr", 32'(mem_wr_o), 32'd1);
    chk("arst_addr", 32'(mem_addr_o), 32'd0);
    chk("arst_wdata", mem_data_o, 32'd0);
    ref_rdata = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 250; n++) begin
      w = 1'($urandom_range(0, 1));
      f = (($urandom_range(0, 3)) != 0) ? int'(3'($urandom_range(0, 5) == 3 ? 2 : 0))
          : int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) f = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 2))
                                         : int'($urandom_range(4, 5));
      a = int'($urandom_range(0, NW * 4 - 1));
      if ($urandom_range(0, 3) != 0) a = (f % 4 == 2) ? (a & ~3) : (f % 4 == 1) ? (a & ~1) : a;
      access(w, f, a, $urandom);
    end

    chk("never_both_low", 32'(both_lo), 32'd0);
    rd0 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
